// File: rtl/clock_set_ctrl_pkg.sv
// Shared encodings for the wall-clock set controller: FSM states, field codes, BCD limits.
package clock_set_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HR   = 2'd1,
    FIELD_MIN  = 2'd2
  } field_e;

  localparam logic [7:0] BCD_59 = 8'h59;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic field_e field_of(input state_e s);
    case (s)
      ST_SET_HR:  return FIELD_HR;
      ST_SET_MIN: return FIELD_MIN;
      default:    return FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button/tick inputs and counter-control outputs between clock_set_ctrl and the clock datapath.
interface clock_set_ctrl_if;
  logic       i_tick;
  logic       i_btn_mode;
  logic       i_btn_up;
  logic       i_btn_down;
  logic [7:0] i_sec_q;
  logic [7:0] i_min_q;
  logic       o_sec_ena;
  logic       o_min_ena;
  logic       o_hr_ena;
  logic       o_inc;
  logic       o_sec_clr;
  logic [1:0] o_field;
  logic       o_blink;
  logic       o_running;

  modport master (
    input  i_tick, i_btn_mode, i_btn_up, i_btn_down, i_sec_q, i_min_q,
    output o_sec_ena, o_min_ena, o_hr_ena, o_inc, o_sec_clr, o_field, o_blink, o_running
  );

  modport slave (
    output i_tick, i_btn_mode, i_btn_up, i_btn_down, i_sec_q, i_min_q,
    input  o_sec_ena, o_min_ena, o_hr_ena, o_inc, o_sec_clr, o_field, o_blink, o_running
  );
endinterface

// File: rtl/clock_set_ctrl_btn_repeat.sv
// Rising-edge detector with hold/auto-repeat counter for one debounced button.
module btn_repeat
  import clock_set_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  input  logic i_clear,
  output logic o_req
);

  localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REP_V  = CNT_W'(REPEAT_CYCLES);

  logic             btn_q;
  logic             rep_q, rep_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press;

  // A zero count means idle: a held button only counts after a fresh press,
  // so a clear while held suppresses repeats until the button is re-pressed.
  always_comb begin
    o_req = 1'b0;
    cnt_d = cnt_q;
    rep_d = rep_q;
    press = i_btn & ~btn_q;
    if (i_clear || !i_btn) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (press) begin
      o_req = 1'b1;
      cnt_d = CNT_W'(1);
      rep_d = 1'b0;
    end else if (cnt_q != '0) begin
      if ((!rep_q && cnt_q == HOLD_V) || (rep_q && cnt_q == REP_V)) begin
        o_req = 1'b1;
        cnt_d = CNT_W'(1);
        rep_d = 1'b1;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // btn_q tracks the button through reset so a press held from reset is not an edge.
  always_ff @(posedge i_clk) begin
    btn_q <= i_btn;
    if (i_reset) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set sequencer for the wall clock: tick cascade in RUN, button-driven field adjust in SET.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  clock_set_ctrl_if.master bus
);

  state_e state_q, state_d;
  field_e field_q, field_d;
  logic   mode_q, mode_edge, clear;
  logic   req_up, req_dn;
  logic   sec_ena_q, sec_ena_d, min_ena_q, min_ena_d, hr_ena_q, hr_ena_d;
  logic   inc_q, inc_d, sec_clr_q, sec_clr_d, blink_q, blink_d, running_q, running_d;

  assign mode_edge = bus.i_btn_mode & ~mode_q;
  assign clear     = (bus.i_btn_up & bus.i_btn_down) | mode_edge;

  btn_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_up (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(bus.i_btn_up), .i_clear(clear), .o_req(req_up)
  );

  btn_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_dn (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(bus.i_btn_down), .i_clear(clear), .o_req(req_dn)
  );

  always_comb begin
    state_d   = state_q;
    sec_ena_d = 1'b0;
    min_ena_d = 1'b0;
    hr_ena_d  = 1'b0;
    inc_d     = 1'b1;
    sec_clr_d = 1'b0;
    blink_d   = blink_q;

    // Cascade keys off the pre-transition state, so a tick still counts on the mode edge.
    if (state_q == ST_RUN && bus.i_tick) begin
      sec_ena_d = 1'b1;
      min_ena_d = (bus.i_sec_q == BCD_59);
      hr_ena_d  = (bus.i_sec_q == BCD_59) && (bus.i_min_q == BCD_59);
    end

    if (mode_edge) begin
      case (state_q)
        ST_RUN:    state_d = ST_SET_HR;
        ST_SET_HR: state_d = ST_SET_MIN;
        default: begin
          state_d   = ST_RUN;
          sec_clr_d = 1'b1;
        end
      endcase
    end else if (state_q != ST_RUN && (req_up || req_dn)) begin
      inc_d = req_up;
      if (state_q == ST_SET_HR) hr_ena_d = 1'b1;
      else                      min_ena_d = 1'b1;
    end

    if (state_d == ST_RUN || state_d != state_q) blink_d = 1'b1;
    else if (bus.i_tick)                         blink_d = ~blink_q;

    field_d   = field_of(state_d);
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge i_clk) begin
    mode_q <= bus.i_btn_mode;
    if (i_reset) begin
      state_q   <= ST_RUN;
      field_q   <= FIELD_NONE;
      sec_ena_q <= 1'b0;
      min_ena_q <= 1'b0;
      hr_ena_q  <= 1'b0;
      inc_q     <= 1'b1;
      sec_clr_q <= 1'b0;
      blink_q   <= 1'b1;
      running_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      field_q   <= field_d;
      sec_ena_q <= sec_ena_d;
      min_ena_q <= min_ena_d;
      hr_ena_q  <= hr_ena_d;
      inc_q     <= inc_d;
      sec_clr_q <= sec_clr_d;
      blink_q   <= blink_d;
      running_q <= running_d;
    end
  end

  assign bus.o_sec_ena = sec_ena_q;
  assign bus.o_min_ena = min_ena_q;
  assign bus.o_hr_ena  = hr_ena_q;
  assign bus.o_inc     = inc_q;
  assign bus.o_sec_clr = sec_clr_q;
  assign bus.o_field   = field_q;
  assign bus.o_blink   = blink_q;
  assign bus.o_running = running_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Cycle-by-cycle vector bench for clock_set_ctrl with short hold/repeat periods.
module tb_clock_set_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clock_set_ctrl_if bus();

  clock_set_ctrl #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  // Expected output bits: {sec_ena, min_ena, hr_ena, inc, sec_clr, field[1:0], blink, running}
  typedef struct packed {
    logic       sec, mn, hr, inc, clr;
    logic [1:0] field;
    logic       blink, run;
  } out_t;

  typedef struct packed {
    logic       rst, tick, mode, up, dn;
    logic [7:0] sec, mn;
    out_t       exp;
  } vec_t;

  localparam logic [8:0] RI = 9'b000_1_0_00_1_1;

  out_t        expq[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  vec_t        tbl[26];

  function automatic vec_t mk(input logic r, input logic t, input logic m, input logic u,
                              input logic d, input logic [7:0] s, input logic [7:0] n,
                              input logic [8:0] e);
    vec_t v;
    v.rst = r; v.tick = t; v.mode = m; v.up = u; v.dn = d;
    v.sec = s; v.mn = n; v.exp = e;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    out_t e, a;
    rst = v.rst;
    bus.i_tick = v.tick;
    bus.i_btn_mode = v.mode;
    bus.i_btn_up = v.up;
    bus.i_btn_down = v.dn;
    bus.i_sec_q = v.sec;
    bus.i_min_q = v.mn;
    expq.push_back(v.exp);
    @(posedge clk);
    #1;
    e = expq.pop_front();
    a = {bus.o_sec_ena, bus.o_min_ena, bus.o_hr_ena, bus.o_inc, bus.o_sec_clr,
         bus.o_field, bus.o_blink, bus.o_running};
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: outputs %b, required %b", name, a, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_tick = 1'b0; bus.i_btn_mode = 1'b0; bus.i_btn_up = 1'b0; bus.i_btn_down = 1'b0;
    bus.i_sec_q = '0; bus.i_min_q = '0;

    tbl[0]  = mk(1, 0, 0, 0, 0, 8'h00, 8'h00, RI);
    tbl[1]  = mk(1, 0, 0, 0, 0, 8'h00, 8'h00, RI);
    tbl[2]  = mk(0, 0, 0, 0, 0, 8'h00, 8'h00, RI);
    tbl[3]  = mk(0, 1, 0, 0, 0, 8'h12, 8'h00, 9'b100_1_0_00_1_1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 8'h12, 8'h00, RI);
    tbl[5]  = mk(0, 1, 0, 0, 0, 8'h12, 8'h00, 9'b100_1_0_00_1_1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 8'h12, 8'h00, RI);
    tbl[7]  = mk(0, 1, 0, 0, 0, 8'h12, 8'h00, 9'b100_1_0_00_1_1);
    tbl[8]  = mk(0, 0, 0, 1, 0, 8'h12, 8'h00, RI);
    tbl[9]  = mk(0, 0, 0, 0, 0, 8'h12, 8'h00, RI);
    tbl[10] = mk(0, 1, 0, 0, 0, 8'h59, 8'h59, 9'b111_1_0_00_1_1);
    tbl[11] = mk(0, 0, 0, 0, 0, 8'h59, 8'h59, RI);
    tbl[12] = mk(0, 1, 0, 0, 0, 8'h59, 8'h30, 9'b110_1_0_00_1_1);
    tbl[13] = mk(0, 0, 0, 0, 0, 8'h00, 8'h30, RI);
    tbl[14] = mk(0, 0, 1, 0, 0, 8'h00, 8'h30, 9'b000_1_0_01_1_0);
    tbl[15] = mk(0, 0, 0, 0, 0, 8'h00, 8'h30, 9'b000_1_0_01_1_0);
    tbl[16] = mk(0, 0, 0, 1, 0, 8'h00, 8'h30, 9'b001_1_0_01_1_0);
    tbl[17] = mk(0, 0, 0, 0, 0, 8'h00, 8'h30, 9'b000_1_0_01_1_0);
    tbl[18] = mk(0, 1, 0, 0, 0, 8'h12, 8'h30, 9'b000_1_0_01_0_0);
    tbl[19] = mk(0, 0, 0, 0, 0, 8'h12, 8'h30, 9'b000_1_0_01_0_0);
    tbl[20] = mk(0, 1, 0, 0, 0, 8'h12, 8'h30, 9'b000_1_0_01_1_0);
    tbl[21] = mk(0, 0, 0, 0, 1, 8'h12, 8'h30, 9'b001_0_0_01_1_0);
    tbl[22] = mk(0, 0, 0, 0, 0, 8'h12, 8'h30, 9'b000_1_0_01_1_0);
    tbl[23] = mk(0, 0, 1, 1, 0, 8'h12, 8'h30, 9'b000_1_0_10_1_0);
    tbl[24] = mk(0, 0, 0, 0, 0, 8'h12, 8'h30, 9'b000_1_0_10_1_0);
    tbl[25] = mk(0, 1, 0, 0, 0, 8'h12, 8'h30, 9'b000_1_0_10_0_0);

    for (int i = 0; i < 26; i++) apply(tbl[i], $sformatf("table[%0d]", i));

    // Down held 20 cycles in SET_MIN: pulses at press+1, +9, +13, +17, none after release.
    for (int k = 0; k < 26; k++) begin
      logic       held;
      logic [8:0] e;
      held = (k < 20);
      e = (held && (k == 0 || k == 8 || k == 12 || k == 16)) ? 9'b010_0_0_10_0_0
                                                           : 9'b000_1_0_10_0_0;
      apply(mk(0, 0, 0, 0, held, 8'h00, 8'h00, e), $sformatf("repeat_dn[%0d]", k));
    end

    // Up and down together: no requests; then SET_MIN -> RUN clears seconds.
    for (int k = 0; k < 12; k++)
      apply(mk(0, 0, 0, 1, 1, 8'h00, 8'h00, 9'b000_1_0_10_0_0), $sformatf("both_held[%0d]", k));
    apply(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 9'b000_1_0_10_0_0), "both_release");
    apply(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 9'b000_1_1_00_1_1), "exit_set_min");
    apply(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, RI), "run_after_exit");
    apply(mk(0, 1, 1, 0, 0, 8'h12, 8'h00, 9'b100_1_0_01_1_0), "tick_with_mode");
    apply(mk(0, 0, 0, 0, 0, 8'h12, 8'h00, 9'b000_1_0_01_1_0), "set_hr_idle");

    // Reset mid-repeat in SET_HR with up and mode held through and after reset.
    apply(mk(0, 0, 0, 1, 0, 8'h00, 8'h00, 9'b001_1_0_01_1_0), "hr_press");
    apply(mk(0, 1, 0, 1, 0, 8'h00, 8'h00, 9'b000_1_0_01_0_0), "hr_hold_tick");
    for (int k = 2; k < 8; k++)
      apply(mk(0, 0, 0, 1, 0, 8'h00, 8'h00, 9'b000_1_0_01_0_0), $sformatf("hr_hold[%0d]", k));
    apply(mk(0, 0, 0, 1, 0, 8'h00, 8'h00, 9'b001_1_0_01_0_0), "hr_first_repeat");
    apply(mk(0, 0, 0, 1, 0, 8'h00, 8'h00, 9'b000_1_0_01_0_0), "hr_hold[9]");
    apply(mk(1, 0, 1, 1, 0, 8'h00, 8'h00, RI), "reset_mid_repeat");
    for (int k = 0; k < 12; k++)
      apply(mk(0, 0, 1, 1, 0, 8'h00, 8'h00, RI), $sformatf("held_after_reset[%0d]", k));
    apply(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, RI), "release_all");
    apply(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 9'b000_1_0_01_1_0), "mode_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
